// File: rtl/alu_cmd_pipe.sv
// Command front end for the 4-bit ALU: buffers {a,b,op,tag} commands in a FIFO,
// drives the ALU from the FIFO head and registers result/tag with backpressure.
module alu_cmd_pipe #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [3:0]               cmd_a,
   input  logic [3:0]               cmd_b,
   input  logic [2:0]               cmd_op,
   input  logic [TAG_W-1:0]         cmd_tag,
   output logic [3:0]               alu_a,
   output logic [3:0]               alu_b,
   output logic [2:0]               alu_op,
   input  logic [7:0]               alu_result,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [7:0]               rsp_result,
   output logic                     rsp_err,
   output logic [TAG_W-1:0]         rsp_tag,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = 4 + 4 + 3 + TAG_W;

   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   localparam logic [2:0] OP_MOD = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd5;

   logic [EW-1:0]    mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;

   logic             rsp_valid_q, rsp_valid_d;
   logic [7:0]       rsp_result_q, rsp_result_d;
   logic             rsp_err_q, rsp_err_d;
   logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

   logic             empty;
   logic             full;
   logic             push;
   logic             pop;
   logic             head_err;

   logic [EW-1:0]    head;
   logic [3:0]       head_a;
   logic [3:0]       head_b;
   logic [2:0]       head_op;
   logic [TAG_W-1:0] head_tag;

   assign empty = (level_q == '0);
   assign full  = (level_q == LVL_FULL);

   // Ready is gated by rst_n so upstream sees 0 for the whole reset window.
   assign cmd_ready = rst_n & ~full;

   assign push = cmd_valid & cmd_ready;
   assign pop  = ~empty & (~rsp_valid_q | rsp_ready);

   assign head = mem_q[rd_ptr_q];
   assign {head_a, head_b, head_op, head_tag} = head;

   assign alu_a  = empty ? 4'd0 : head_a;
   assign alu_b  = empty ? 4'd0 : head_b;
   assign alu_op = empty ? 3'd0 : head_op;

   // The ALU leaves divide/modulo by zero undefined; flag it and zero the result.
   assign head_err = ((head_op == OP_MOD) || (head_op == OP_DIV)) && (head_b == 4'd0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {cmd_a, cmd_b, cmd_op, cmd_tag};
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
         level_d = level_q + LVL_ONE;
      end else if (pop && !push) begin
         level_d = level_q - LVL_ONE;
      end
   end

   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_err_d    = rsp_err_q;
      rsp_tag_d    = rsp_tag_q;
      if (pop) begin
         rsp_valid_d  = 1'b1;
         rsp_err_d    = head_err;
         rsp_result_d = head_err ? 8'h00 : alu_result;
         rsp_tag_d    = head_tag;
      end else if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= 8'h00;
         rsp_err_q    <= 1'b0;
         rsp_tag_q    <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_err_q    <= rsp_err_d;
         rsp_tag_q    <= rsp_tag_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_err    = rsp_err_q;
   assign rsp_tag    = rsp_tag_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_alu_cmd_pipe.sv
// Directed bench for alu_cmd_pipe; a behavioural 4-bit ALU closes the loop on alu_*.
module tb_alu_cmd_pipe;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_a;
   logic [3:0] cmd_b;
   logic [2:0] cmd_op;
   logic [3:0] cmd_tag;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [2:0] alu_op;
   logic [7:0] alu_result;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_result;
   logic       rsp_err;
   logic [3:0] rsp_tag;
   logic [2:0] fifo_level;

   int checks;
   int failures;

   alu_cmd_pipe #(.DEPTH(4), .TAG_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_op     (cmd_op),
      .cmd_tag    (cmd_tag),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_err    (rsp_err),
      .rsp_tag    (rsp_tag),
      .fifo_level (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in ALU; returns 8'hEE for x/0 so the error override is observable.
   always_comb begin
      alu_result = 8'h00;
      case (alu_op)
         3'd0: alu_result = {4'd0, alu_a} + {4'd0, alu_b};
         3'd1: alu_result = {4'd0, alu_a} * {4'd0, alu_b};
         3'd2: alu_result = (alu_b == 4'd0) ? 8'hEE : {4'd0, alu_a % alu_b};
         3'd3: alu_result = {4'd0, alu_a & alu_b};
         3'd4: alu_result = {4'd0, alu_a} - {4'd0, alu_b};
         3'd5: alu_result = (alu_b == 4'd0) ? 8'hEE : {4'd0, alu_a / alu_b};
         3'd6: alu_result = {4'd0, alu_a | alu_b};
         3'd7: alu_result = {4'd0, alu_a ^ alu_b};
         default: alu_result = 8'h00;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_cmd(input logic [3:0] a, input logic [3:0] b,
                            input logic [2:0] op, input logic [3:0] tag);
      cmd_valid = 1'b1;
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
      cmd_tag   = tag;
   endtask

   task automatic idle(input int n);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%0b exp=0", cmd_ready); end
      checks++;
      if (rsp_valid !== 1'b0 || rsp_result !== 8'h00 || rsp_err !== 1'b0 || rsp_tag !== 4'h0) begin
         failures++;
         $display("FAIL reset_rsp got v=%0b r=%0h e=%0b t=%0h exp all 0", rsp_valid, rsp_result, rsp_err, rsp_tag);
      end
      checks++;
      if (fifo_level !== 3'd0 || alu_a !== 4'd0 || alu_b !== 4'd0 || alu_op !== 3'd0) begin
         failures++;
         $display("FAIL reset_fifo_alu got lvl=%0d a=%0h b=%0h op=%0d exp 0", fifo_level, alu_a, alu_b, alu_op);
      end
      #12 rst_n = 1'b1;
      tick();
      checks++;
      if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%0b exp=1", cmd_ready); end
   endtask

   task automatic test_single();
      rsp_ready = 1'b1;
      drive_cmd(4'd3, 4'd4, 3'd0, 4'd1);
      tick();
      cmd_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_c1_valid got=%0b exp=0", rsp_valid); end
      checks++;
      if (fifo_level !== 3'd1 || alu_a !== 4'd3 || alu_b !== 4'd4) begin
         failures++;
         $display("FAIL single_c1_head got lvl=%0d a=%0h b=%0h exp lvl=1 a=3 b=4", fifo_level, alu_a, alu_b);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 8'h07 || rsp_err !== 1'b0 || rsp_tag !== 4'd1) begin
         failures++;
         $display("FAIL single_c2_rsp got v=%0b r=%0h e=%0b t=%0h exp v=1 r=07 e=0 t=1", rsp_valid, rsp_result, rsp_err, rsp_tag);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_c3_valid got=%0b exp=0", rsp_valid); end
   endtask

   task automatic test_streaming();
      logic [3:0] va [8];
      logic [3:0] vb [8];
      logic [2:0] vo [8];
      logic [3:0] vt [8];
      logic [7:0] vr [8];
      va = '{4'd15, 4'd2, 4'd6, 4'd12, 4'd9, 4'd13, 4'd5,  4'd7};
      vb = '{4'd15, 4'd5, 4'd3, 4'd10, 4'd4, 4'd3,  4'd10, 4'd5};
      vo = '{3'd1,  3'd4, 3'd0, 3'd3,  3'd2, 3'd5,  3'd6,  3'd7};
      vt = '{4'd2,  4'd3, 4'd4, 4'd5,  4'd6, 4'd7,  4'd8,  4'd10};
      vr = '{8'hE1, 8'hFD, 8'h09, 8'h08, 8'h01, 8'h04, 8'h0F, 8'h02};
      rsp_ready = 1'b1;
      for (int c = 0; c <= 10; c++) begin
         if (c < 8) begin
            drive_cmd(va[c], vb[c], vo[c], vt[c]);
            checks++;
            if (cmd_ready !== 1'b1) begin failures++; $display("FAIL stream_ready c=%0d got=%0b exp=1", c, cmd_ready); end
         end else begin
            cmd_valid = 1'b0;
         end
         checks++;
         if (c >= 2 && c <= 9) begin
            if (rsp_valid !== 1'b1 || rsp_result !== vr[c-2] || rsp_tag !== vt[c-2] || rsp_err !== 1'b0) begin
               failures++;
               $display("FAIL stream_rsp c=%0d got v=%0b r=%0h t=%0h e=%0b exp v=1 r=%0h t=%0h e=0",
                        c, rsp_valid, rsp_result, rsp_tag, rsp_err, vr[c-2], vt[c-2]);
            end
         end else if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_idle c=%0d got v=%0b exp v=0", c, rsp_valid);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      int n;
      int accepted;
      logic [7:0] r0;
      logic [3:0] t0;
      n = 0;
      rsp_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         drive_cmd(4'(n), 4'd1, 3'd0, 4'(11 + n));
         accepted = int'(cmd_ready);
         tick();
         n += accepted;
         if (c == 2) begin
            r0 = rsp_result;
            t0 = rsp_tag;
         end
      end
      checks++;
      if (n !== 5) begin failures++; $display("FAIL bp_accepts got=%0d exp=5", n); end
      checks++;
      if (cmd_ready !== 1'b0 || fifo_level !== 3'd4) begin
         failures++;
         $display("FAIL bp_full got rdy=%0b lvl=%0d exp rdy=0 lvl=4", cmd_ready, fifo_level);
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_tag !== 4'd11 || rsp_result !== 8'h01 || rsp_tag !== t0 || rsp_result !== r0) begin
         failures++;
         $display("FAIL bp_stable got v=%0b r=%0h t=%0h exp v=1 r=01 t=b (earlier r=%0h t=%0h)",
                  rsp_valid, rsp_result, rsp_tag, r0, t0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int k = 0; k <= 5; k++) begin
         if (k == 0 || k == 1) begin
            checks++;
            if (cmd_ready !== (k == 1)) begin
               failures++;
               $display("FAIL bp_ready_rise k=%0d got=%0b exp=%0b", k, cmd_ready, (k == 1));
            end
         end
         checks++;
         if (k < 5) begin
            if (rsp_valid !== 1'b1 || rsp_tag !== 4'(11 + k) || rsp_result !== 8'(k + 1)) begin
               failures++;
               $display("FAIL bp_drain k=%0d got v=%0b r=%0h t=%0h exp v=1 r=%0h t=%0h",
                        k, rsp_valid, rsp_result, rsp_tag, k + 1, 11 + k);
            end
         end else if (rsp_valid !== 1'b0 || fifo_level !== 3'd0) begin
            failures++;
            $display("FAIL bp_drain_end got v=%0b lvl=%0d exp v=0 lvl=0", rsp_valid, fifo_level);
         end
         tick();
      end
   endtask

   task automatic test_div_zero();
      rsp_ready = 1'b1;
      for (int c = 0; c <= 5; c++) begin
         case (c)
            0: drive_cmd(4'd9, 4'd0, 3'd5, 4'd1);
            1: drive_cmd(4'd9, 4'd0, 3'd2, 4'd2);
            2: drive_cmd(4'd9, 4'd2, 3'd5, 4'd3);
            default: cmd_valid = 1'b0;
         endcase
         if (c == 2 || c == 3) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_result !== 8'h00 || rsp_tag !== 4'(c - 1)) begin
               failures++;
               $display("FAIL divz_err c=%0d got v=%0b e=%0b r=%0h t=%0h exp v=1 e=1 r=00 t=%0h",
                        c, rsp_valid, rsp_err, rsp_result, rsp_tag, c - 1);
            end
         end else if (c == 4) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_result !== 8'h04 || rsp_tag !== 4'd3) begin
               failures++;
               $display("FAIL divz_ok got v=%0b e=%0b r=%0h t=%0h exp v=1 e=0 r=04 t=3",
                        rsp_valid, rsp_err, rsp_result, rsp_tag);
            end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int exp_idx;
      exp_idx = 0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_cmd(4'(i), 4'd3, 3'd0, 4'(i));
         tick();
      end
      for (int i = 3; i < 20; i++) begin
         drive_cmd(4'(i), 4'd3, 3'd0, 4'(i));
         rsp_ready = 1'b1;
         checks++;
         if (fifo_level !== 3'd2) begin failures++; $display("FAIL b2b_level i=%0d got=%0d exp=2", i, fifo_level); end
         if (rsp_valid) begin
            checks++;
            if (rsp_tag !== 4'(exp_idx) || rsp_result !== 8'((exp_idx % 16) + 3)) begin
               failures++;
               $display("FAIL b2b_order got t=%0h r=%0h exp t=%0h r=%0h", rsp_tag, rsp_result, exp_idx % 16, (exp_idx % 16) + 3);
            end
            exp_idx++;
         end
         tick();
      end
      cmd_valid = 1'b0;
      checks++;
      if (fifo_level !== 3'd2) begin failures++; $display("FAIL b2b_level_end got=%0d exp=2", fifo_level); end
      for (int k = 0; k < 10 && exp_idx < 20; k++) begin
         if (rsp_valid) begin
            checks++;
            if (rsp_tag !== 4'(exp_idx) || rsp_result !== 8'((exp_idx % 16) + 3)) begin
               failures++;
               $display("FAIL b2b_order got t=%0h r=%0h exp t=%0h r=%0h", rsp_tag, rsp_result, exp_idx % 16, (exp_idx % 16) + 3);
            end
            exp_idx++;
         end
         tick();
      end
      checks++;
      if (exp_idx !== 20 || rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_count got n=%0d v=%0b exp n=20 v=0", exp_idx, rsp_valid);
      end
   endtask

   task automatic test_reset_midop();
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_cmd(4'(i), 4'd1, 3'd0, 4'(i + 4));
         tick();
      end
      cmd_valid = 1'b0;
      checks++;
      if (fifo_level !== 3'd3 || rsp_valid !== 1'b1) begin
         failures++;
         $display("FAIL midrst_setup got lvl=%0d v=%0b exp lvl=3 v=1", fifo_level, rsp_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || fifo_level !== 3'd0 || cmd_ready !== 1'b0) begin
         failures++;
         $display("FAIL midrst_async got v=%0b lvl=%0d rdy=%0b exp v=0 lvl=0 rdy=0", rsp_valid, fifo_level, cmd_ready);
      end
      #14 rst_n = 1'b1;
      tick();
      rsp_ready = 1'b1;
      checks++;
      if (cmd_ready !== 1'b1 || fifo_level !== 3'd0) begin
         failures++;
         $display("FAIL midrst_release got rdy=%0b lvl=%0d exp rdy=1 lvl=0", cmd_ready, fifo_level);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (rsp_valid !== 1'b0) begin failures++; $display("FAIL midrst_stale k=%0d got v=%0b exp v=0", k, rsp_valid); end
         tick();
      end
      drive_cmd(4'd7, 4'd5, 3'd7, 4'd9);
      tick();
      cmd_valid = 1'b0;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 8'h02 || rsp_tag !== 4'd9 || rsp_err !== 1'b0) begin
         failures++;
         $display("FAIL midrst_new got v=%0b r=%0h t=%0h e=%0b exp v=1 r=02 t=9 e=0", rsp_valid, rsp_result, rsp_tag, rsp_err);
      end
      tick();
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_a     = 4'd0;
      cmd_b     = 4'd0;
      cmd_op    = 3'd0;
      cmd_tag   = 4'd0;
      rsp_ready = 1'b0;
      test_reset();
      test_single();
      idle(2);
      test_streaming();
      idle(2);
      test_backpressure();
      idle(2);
      test_div_zero();
      idle(2);
      test_back_to_back();
      idle(2);
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
